// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg
//   Shared types and constants for the MIPS core Wishbone master side:
//   arbiter state encoding, master index constants, bus widths, and a
//   helper that turns a master index into a one-hot grant vector.
package mips_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } arb_state_t;

    localparam logic M_DATA  = 1'b0;
    localparam logic M_INSTR = 1'b1;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    function automatic logic [1:0] grant_onehot(input logic idx);
        return (idx == M_INSTR) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog
//   Stall counter for the arbiter's bus watchdog. Counts cycles while inc
//   is high, returns to zero on clr, and flags expire once the count has
//   reached TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0 disables it (expire stays 0).
// Ports
//   clk, rst  : clock, synchronous active-high reset
//   clr       : zero the counter (takes priority over inc)
//   inc       : count one stalled cycle
//   expire    : count is at the last allowed stall cycle
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LIMIT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LIMIT_I);
    localparam bit ENABLED = (TIMEOUT_CYCLES > 0);

    logic [CNT_W-1:0] count;

    // Saturates at LIMIT; the arbiter leaves BUSY when it gets there anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && ENABLED && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = ENABLED && (count == LIMIT);

endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2
//   Two-master Wishbone arbiter. Master 0 is the data master, master 1 the
//   instruction fetch master. Round-robin on ties, the owner keeps the bus
//   for as long as it holds cyc, and a watchdog terminates a stalled strobe
//   with a one-cycle err pulse.
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   m0_* / m1_*                 : master-side Wishbone (cyc/stb/we/sel/adr/dat in,
//                                 ack/err/dat out)
//   s_*_o / s_dat_i / s_ack_i   : shared slave-side Wishbone
//   grant_o                     : one-hot current owner, 00 when idle
//
// state   | meaning
// IDLE    | no owner, slave outputs 0, arbitrating on cyc
// BUSY    | owner drives the slave bus, ack passed through
// ERR     | watchdog fired, bus forced to 0, wait for owner to drop cyc
module wb_arbiter2
    import mips_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic [WB_DAT_W-1:0] m0_dat_o,

    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [WB_DAT_W-1:0] m1_dat_o,

    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    input  logic [WB_DAT_W-1:0] s_dat_i,
    input  logic                s_ack_i,

    output logic [1:0]          grant_o
);

    arb_state_t state;
    logic       owner;
    logic       last;
    logic       err_pulse;

    logic       next_owner;
    logic       owner_cyc;
    logic       busy_out;
    logic       err_live;
    logic       wd_clr;
    logic       wd_inc;
    logic       wd_expire;
    logic       to_err;

    // Tie goes to whoever was not served last; otherwise the lone requester.
    always_comb begin
        if (m0_cyc_i && m1_cyc_i) begin
            next_owner = ~last;
        end else if (m1_cyc_i) begin
            next_owner = M_INSTR;
        end else begin
            next_owner = M_DATA;
        end
    end

    assign owner_cyc = (owner == M_INSTR) ? m1_cyc_i : m0_cyc_i;

    // Gating with rst drops the slave bus in the very cycle reset is seen,
    // so a reset mid-transfer never leaves a strobe on the bus.
    assign busy_out = (state == ST_BUSY) && !rst;
    assign err_live = (state == ST_ERR) && err_pulse && !rst;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        if (busy_out) begin
            if (owner == M_INSTR) begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
            end else begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
            end
            // Read data goes to both; each master qualifies it with its own ack.
            m0_dat_o = s_dat_i;
            m1_dat_o = s_dat_i;
        end
    end

    assign m0_err_o = err_live && (owner == M_DATA);
    assign m1_err_o = err_live && (owner == M_INSTR);
    assign grant_o  = ((state != ST_IDLE) && !rst) ? grant_onehot(owner) : 2'b00;

    assign wd_inc = (state == ST_BUSY) && s_stb_o && !s_ack_i;
    assign wd_clr = (state != ST_BUSY) || !s_stb_o || s_ack_i;
    // A same-cycle ack beats the timeout.
    assign to_err = wd_inc && wd_expire;

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .inc   (wd_inc),
        .expire(wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= M_DATA;
            last      <= M_INSTR;
            err_pulse <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    err_pulse <= 1'b0;
                    if (m0_cyc_i || m1_cyc_i) begin
                        owner <= next_owner;
                        last  <= next_owner;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!owner_cyc) begin
                        state <= ST_IDLE;
                    end else if (to_err) begin
                        state     <= ST_ERR;
                        err_pulse <= 1'b1;
                    end
                end
                ST_ERR: begin
                    err_pulse <= 1'b0;
                    if (!owner_cyc) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    err_pulse <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [31:0] s_dat_i;
    logic        s_ack_i;

    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [1:0]  grant_o;

    logic        n_m0_ack_o, n_m0_err_o, n_m1_ack_o, n_m1_err_o;
    logic [31:0] n_m0_dat_o, n_m1_dat_o;
    logic        n_s_cyc_o, n_s_stb_o, n_s_we_o;
    logic [3:0]  n_s_sel_o;
    logic [31:0] n_s_adr_o, n_s_dat_o;
    logic [1:0]  n_grant_o;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o)
    );

    wb_arbiter2 #(.TIMEOUT_CYCLES(0)) dut_nt (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(n_m0_ack_o), .m0_err_o(n_m0_err_o),
        .m0_dat_o(n_m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(n_m1_ack_o), .m1_err_o(n_m1_err_o),
        .m1_dat_o(n_m1_dat_o),
        .s_cyc_o(n_s_cyc_o), .s_stb_o(n_s_stb_o), .s_we_o(n_s_we_o), .s_sel_o(n_s_sel_o),
        .s_adr_o(n_s_adr_o), .s_dat_o(n_s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(n_grant_o)
    );

    int checks = 0;
    int errors = 0;

    int m0_ack_seen = 0, m1_ack_seen = 0, m0_err_seen = 0, m1_err_seen = 0, nt_err_seen = 0;

    // Reference model: who owns the bus (-1 = nobody), whether the owner has
    // been cut off by the watchdog, and how many strobe cycles in a row have
    // gone unanswered.
    int md_owner = -1;
    int md_last  = 1;
    int md_stall = 0;
    bit md_cut   = 0;
    bit md_first = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic cyc, input logic stb, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
        m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
    endtask

    task automatic set_m1(input logic cyc, input logic stb, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
        m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
    endtask

    // Checks every output against the model mid-cycle, then advances the model
    // across the rising edge using the same inputs.
    task automatic cycle();
        logic [79:0] e_s, e_m0, e_m1, e_d0, e_d1, e_g;
        bit ocyc, ostb;
        #3;
        e_s = '0; e_m0 = '0; e_m1 = '0; e_d0 = '0; e_d1 = '0; e_g = '0;
        if (!rst && md_owner >= 0) begin
            e_g = (md_owner == 1) ? 80'd2 : 80'd1;
            if (!md_cut) begin
                if (md_owner == 0) begin
                    e_s  = {9'd0, m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
                    e_m0 = {78'd0, s_ack_i, 1'b0};
                end else begin
                    e_s  = {9'd0, m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
                    e_m1 = {78'd0, s_ack_i, 1'b0};
                end
                e_d0 = {48'd0, s_dat_i};
                e_d1 = {48'd0, s_dat_i};
            end else if (md_first) begin
                if (md_owner == 0) e_m0 = 80'd1; else e_m1 = 80'd1;
            end
        end
        chk("slave_bus", {9'd0, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}, e_s);
        chk("m0_ack_err", {78'd0, m0_ack_o, m0_err_o}, e_m0);
        chk("m1_ack_err", {78'd0, m1_ack_o, m1_err_o}, e_m1);
        chk("m0_rdata", {48'd0, m0_dat_o}, e_d0);
        chk("m1_rdata", {48'd0, m1_dat_o}, e_d1);
        chk("grant", {78'd0, grant_o}, e_g);
        if (m0_ack_o) m0_ack_seen++;
        if (m1_ack_o) m1_ack_seen++;
        if (m0_err_o) m0_err_seen++;
        if (m1_err_o) m1_err_seen++;
        if (n_m0_err_o || n_m1_err_o) nt_err_seen++;
        @(posedge clk);
        if (rst) begin
            md_owner = -1; md_last = 1; md_stall = 0; md_cut = 0; md_first = 0;
        end else if (md_owner < 0) begin
            if (m0_cyc_i || m1_cyc_i) begin
                if (m0_cyc_i && m1_cyc_i) md_owner = 1 - md_last;
                else md_owner = m1_cyc_i ? 1 : 0;
                md_last = md_owner; md_stall = 0; md_cut = 0; md_first = 0;
            end
        end else begin
            ocyc = (md_owner == 1) ? m1_cyc_i : m0_cyc_i;
            ostb = (md_owner == 1) ? m1_stb_i : m0_stb_i;
            md_first = 0;
            if (!ocyc) begin
                md_owner = -1; md_cut = 0;
            end else if (!md_cut) begin
                if (ostb && !s_ack_i) begin
                    md_stall++;
                    if (md_stall == T) begin md_cut = 1; md_first = 1; end
                end else begin
                    md_stall = 0;
                end
            end
        end
        #1;
    endtask

    int a0, a1, e0, e1, nte;
    bit stall_mode;

    initial begin
        rst = 1'b1;
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
        s_dat_i = 32'h0; s_ack_i = 1'b0;
        #1;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // Single master write with two wait states.
        a0 = m0_ack_seen; a1 = m1_ack_seen; e1 = m1_err_seen;
        set_m0(1, 1, 1, 4'hF, 32'h0000_0400, 32'hDEAD_BEEF);
        cycle();
        chk("t1_stb_after_cyc", {79'd0, s_stb_o}, 80'd1);
        chk("t1_adr", {48'd0, s_adr_o}, 80'h400);
        cycle(); cycle();
        s_ack_i = 1'b1; cycle();
        s_ack_i = 1'b0; set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle(); cycle();
        chk("t1_ack_pulses", m0_ack_seen - a0, 80'd1);
        chk("t1_m1_quiet", (m1_ack_seen - a1) + (m1_err_seen - e1), 80'd0);

        // Tie rounds straight after reset: m0 first, then alternate.
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            logic [1:0] eg;
            eg = (r % 2 == 0) ? 2'b01 : 2'b10;
            set_m0(1, 1, 0, 4'hF, 32'h100 + r, 32'h0);
            set_m1(1, 1, 0, 4'hF, 32'h200 + r, 32'h0);
            cycle();
            chk("t2_tie_grant", {78'd0, grant_o}, {78'd0, eg});
            s_ack_i = 1'b1; s_dat_i = 32'hA0 + r; cycle();
            s_ack_i = 1'b0;
            set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
            set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
            cycle();
        end

        // m1 burst of four reads while m0 waits.
        a0 = m0_ack_seen; a1 = m1_ack_seen;
        set_m1(1, 1, 0, 4'hF, 32'h1000, 32'h0);
        cycle();
        set_m0(1, 1, 0, 4'hF, 32'h2000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1'b1; s_dat_i = 32'h10 + i; set_m1(1, 1, 0, 4'hF, 32'h1000 + 4 * i, 32'h0);
            cycle();
            chk("t3_hold_m1", {78'd0, grant_o}, 80'd2);
        end
        s_ack_i = 1'b0; set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle();
        chk("t3_gap", {78'd0, grant_o}, 80'd0);
        cycle();
        chk("t3_m0_grant", {78'd0, grant_o}, 80'd1);
        chk("t3_m1_acks", m1_ack_seen - a1, 80'd4);
        chk("t3_m0_held_off", m0_ack_seen - a0, 80'd0);
        s_ack_i = 1'b1; cycle();
        s_ack_i = 1'b0; set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle();

        // Watchdog timeout on m0, then a late ack that must not get through.
        a0 = m0_ack_seen; e0 = m0_err_seen;
        set_m0(1, 1, 1, 4'h3, 32'h3000, 32'h1234_5678);
        cycle();
        repeat (T) cycle();
        chk("t4_err_at_T", {79'd0, m0_err_o}, 80'd1);
        chk("t4_stb_dropped", {79'd0, s_stb_o}, 80'd0);
        s_ack_i = 1'b1; cycle(); cycle();
        s_ack_i = 1'b0;
        chk("t4_err_pulses", m0_err_seen - e0, 80'd1);
        chk("t4_no_late_ack", m0_ack_seen - a0, 80'd0);
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle();
        chk("t4_idle", {78'd0, grant_o}, 80'd0);

        // Ack on the last allowed stall cycle wins over the watchdog.
        a0 = m0_ack_seen; e0 = m0_err_seen;
        set_m0(1, 1, 0, 4'hF, 32'h4000, 32'h0);
        cycle();
        repeat (T - 1) cycle();
        s_ack_i = 1'b1; s_dat_i = 32'h5A5A_5A5A; cycle();
        s_ack_i = 1'b0; cycle(); cycle();
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle();
        chk("t5_race_ack", m0_ack_seen - a0, 80'd1);
        chk("t5_race_no_err", m0_err_seen - e0, 80'd0);

        // Disabled watchdog: a long stall never produces err.
        nte = nt_err_seen;
        set_m0(1, 1, 0, 4'hF, 32'h5000, 32'h0);
        cycle();
        repeat (1000) cycle();
        chk("t6_nt_no_err", nt_err_seen - nte, 80'd0);
        chk("t6_nt_still_strobing", {79'd0, n_s_stb_o}, 80'd1);
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle(); cycle();

        // Reset in the middle of a transfer.
        set_m1(1, 1, 1, 4'hC, 32'h6000, 32'hCAFE_F00D);
        cycle(); cycle();
        rst = 1'b1;
        #1;
        chk("t7_rst_cyc_drop", {79'd0, s_cyc_o}, 80'd0);
        cycle();
        rst = 1'b0;
        set_m0(1, 1, 0, 4'hF, 32'h7000, 32'h0);
        cycle();
        chk("t7_tie_after_rst", {78'd0, grant_o}, 80'd1);
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle();

        // Random traffic against the model.
        stall_mode = 0;
        for (int n = 0; n < 2000; n++) begin
            logic c0, c1;
            c0 = m0_cyc_i ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            c1 = m1_cyc_i ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            set_m0(c0, c0 & ($urandom_range(3) != 0), 1'($urandom), 4'($urandom), $urandom, $urandom);
            set_m1(c1, c1 & ($urandom_range(3) != 0), 1'($urandom), 4'($urandom), $urandom, $urandom);
            if ($urandom_range(49) == 0) stall_mode = ~stall_mode;
            s_ack_i = stall_mode ? 1'b0 : ($urandom_range(2) == 0);
            s_dat_i = $urandom;
            rst = ($urandom_range(199) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
